// File: rtl/adc_qsys_ocimem_pkg.sv
// Shared types and jdo field positions for the Nios II on-chip debug memory controller.
package adc_qsys_ocimem_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_LSB   = 17;
    localparam int RDFLAG_BIT = 34;
    localparam int WDATA_LSB  = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_JRD  = 3'd1,
        ST_JCAP = 3'd2,
        ST_JWR  = 3'd3,
        ST_CRD  = 3'd4
    } ocimem_state_e;

endpackage

// File: rtl/adc_qsys_ocimem_ram.sv
// Single-port debug RAM: byte-lane writes, registered read data with a read enable.
module adc_qsys_ocimem_ram
    import adc_qsys_ocimem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     addr,
    input  logic [3:0]        we,
    input  logic              re,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(1<<AW)-1];

    // Storage array: contents survive reset, only enabled byte lanes change
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read data register: holds the last word read so callers see it stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 32'h0000_0000;
        end else if (re) begin
            rdata <= mem_r[addr];
        end else begin
            rdata <= rdata;
        end
    end

endmodule

// File: rtl/adc_qsys_debug_ocimem_ctrl.sv
// Debug memory controller: JTAG monitor access to a RAM shared with a CPU Avalon-MM slave.
// Optional address auto-increment after each JTAG access: ADC_QSYS_OCIMEM_AUTOINC_EN.
module adc_qsys_debug_ocimem_ctrl
    import adc_qsys_ocimem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_overrun,
    input  logic [AW-1:0]     avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest
);

    ocimem_state_e     state_r;
    logic [AW-1:0]     mon_a_reg_r;
    logic              jtag_any_s;
    logic              jtag_multi_s;
    logic              cpu_grant_s;
    logic [AW-1:0]     jdo_addr_s;
    logic              jdo_rdflag_s;
    logic [DATA_W-1:0] jdo_wdata_s;
    logic [AW-1:0]     ram_addr_s;
    logic [3:0]        ram_we_s;
    logic              ram_re_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic [DATA_W-1:0] ram_rdata_s;
    logic              unused_jdo_s;

    assign jdo_addr_s   = jdo[ADDR_LSB +: AW];
    assign jdo_rdflag_s = jdo[RDFLAG_BIT];
    assign jdo_wdata_s  = jdo[WDATA_LSB +: DATA_W];
    assign unused_jdo_s = ^{jdo[37:35], jdo[2:0]};

    assign jtag_any_s   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign jtag_multi_s = (take_action_ocimem_b & take_action_ocimem_a)
                        | (take_action_ocimem_b & take_no_action_ocimem_a)
                        | (take_action_ocimem_a & take_no_action_ocimem_a);
    assign cpu_grant_s  = (state_r == ST_IDLE) && !jtag_any_s;

    // Sequencer: JTAG command decode, monitor registers and overrun flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            mon_a_reg_r  <= '0;
            MonDReg      <= 32'h0000_0000;
            jtag_overrun <= 1'b0;
        end else begin
            if (jtag_any_s && ((state_r != ST_IDLE) || jtag_multi_s)) begin
                jtag_overrun <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (take_action_ocimem_b) begin
                        MonDReg <= jdo_wdata_s;
                        state_r <= ST_JWR;
                    end else if (take_action_ocimem_a) begin
                        mon_a_reg_r <= jdo_addr_s;
                        state_r     <= jdo_rdflag_s ? ST_JRD : ST_IDLE;
                    end else if (take_no_action_ocimem_a) begin
                        state_r <= ST_JRD;
                    end else if (avs_read) begin
                        state_r <= ST_CRD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_JRD: begin
                    state_r <= ST_JCAP;
                end
                ST_JCAP: begin
                    MonDReg <= ram_rdata_s;
`ifdef ADC_QSYS_OCIMEM_AUTOINC_EN
                    mon_a_reg_r <= mon_a_reg_r + {{(AW-1){1'b0}}, 1'b1};
`endif
                    state_r <= ST_IDLE;
                end
                ST_JWR: begin
`ifdef ADC_QSYS_OCIMEM_AUTOINC_EN
                    mon_a_reg_r <= mon_a_reg_r + {{(AW-1){1'b0}}, 1'b1};
`endif
                    state_r <= ST_IDLE;
                end
                ST_CRD: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM port arbitration: JTAG owns the port outside IDLE, CPU only when granted
    always_comb begin
        ram_addr_s  = mon_a_reg_r;
        ram_we_s    = 4'b0000;
        ram_re_s    = 1'b0;
        ram_wdata_s = MonDReg;
        case (state_r)
            ST_JRD: begin
                ram_re_s = 1'b1;
            end
            ST_JWR: begin
                ram_we_s = 4'b1111;
            end
            ST_IDLE: begin
                if (cpu_grant_s) begin
                    ram_addr_s  = avs_address;
                    ram_wdata_s = avs_writedata;
                    ram_we_s    = avs_write ? avs_byteenable : 4'b0000;
                    ram_re_s    = avs_read;
                end else begin
                    ram_re_s = 1'b0;
                end
            end
            default: begin
                ram_re_s = 1'b0;
            end
        endcase
    end

    // CPU stall: blocked by JTAG, or waiting for the registered read to come back
    always_comb begin
        if (state_r == ST_CRD) begin
            avs_waitrequest = 1'b0;
        end else begin
            avs_waitrequest = ((avs_read | avs_write) & ((state_r != ST_IDLE) | jtag_any_s))
                            | (cpu_grant_s & avs_read);
        end
    end

    // A write still pending when reset arrives must not reach the array
    adc_qsys_ocimem_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .rst_n (reset_n),
        .addr  (ram_addr_s),
        .we    (ram_we_s & {4{reset_n}}),
        .re    (ram_re_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign avs_readdata = ram_rdata_s;

endmodule
